// File: rtl/ant_steer.sv
// Steers an ant toward a target cell: aims at the octant of the shortest toroidal
// path, rotates one octant per cycle by the shorter direction, then steps one cell.
module ant_steer #(
  parameter int X_bits = 8,
  parameter int Y_bits = 7
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [X_bits-1:0] X_in,
  input  logic [Y_bits-1:0] Y_in,
  input  logic [2:0]        dir_in,
  input  logic [X_bits-1:0] tgt_X,
  input  logic [Y_bits-1:0] tgt_Y,
  output logic              busy,
  output logic              done,
  output logic              arrived,
  output logic [X_bits-1:0] X_out,
  output logic [Y_bits-1:0] Y_out,
  output logic [2:0]        dir_out,
  output logic [2:0]        turns
);

  typedef enum logic [2:0] {S_IDLE, S_AIM, S_TURN, S_STEP, S_DONE} state_t;

  // Sign codes for dx/dy: zero, positive, negative.
  localparam logic [1:0] SG_Z = 2'b00;
  localparam logic [1:0] SG_P = 2'b01;
  localparam logic [1:0] SG_N = 2'b11;

  localparam logic [X_bits-1:0] X_ONE = X_bits'(1);
  localparam logic [Y_bits-1:0] Y_ONE = Y_bits'(1);

  state_t state_q, state_d;

  logic [X_bits-1:0] x_q, tgt_x_q;
  logic [Y_bits-1:0] y_q, tgt_y_q;
  logic [2:0]        dir_q, desired_q, turns_q;
  logic              right_q, arrived_q;

  logic [X_bits-1:0] dx, x_step;
  logic [Y_bits-1:0] dy, y_step;
  logic [1:0]        sx, sy;
  logic [2:0]        desired_c, delta_c, dir_turn;
  logic              at_target;

  // Aim: wrapped differences read as two's complement give the shortest path.
  always_comb begin
    dx        = tgt_x_q - x_q;
    dy        = tgt_y_q - y_q;
    sx        = (dx == '0) ? SG_Z : (dx[X_bits-1] ? SG_N : SG_P);
    sy        = (dy == '0) ? SG_Z : (dy[Y_bits-1] ? SG_N : SG_P);
    at_target = (sx == SG_Z) && (sy == SG_Z);
    case ({sx, sy})
      {SG_Z, SG_N}: desired_c = 3'd0;
      {SG_P, SG_N}: desired_c = 3'd1;
      {SG_P, SG_Z}: desired_c = 3'd2;
      {SG_P, SG_P}: desired_c = 3'd3;
      {SG_Z, SG_P}: desired_c = 3'd4;
      {SG_N, SG_P}: desired_c = 3'd5;
      {SG_N, SG_Z}: desired_c = 3'd6;
      {SG_N, SG_N}: desired_c = 3'd7;
      default:      desired_c = dir_q;
    endcase
    delta_c  = desired_c - dir_q;
    dir_turn = right_q ? dir_q + 3'd1 : dir_q - 3'd1;
  end

  // Front cell of the current heading; 3-bit and field-width arithmetic wraps naturally.
  always_comb begin
    x_step = x_q;
    y_step = y_q;
    case (dir_q)
      3'd1, 3'd2, 3'd3: x_step = x_q + X_ONE;
      3'd5, 3'd6, 3'd7: x_step = x_q - X_ONE;
      default:          x_step = x_q;
    endcase
    case (dir_q)
      3'd7, 3'd0, 3'd1: y_step = y_q - Y_ONE;
      3'd3, 3'd4, 3'd5: y_step = y_q + Y_ONE;
      default:          y_step = y_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_AIM;
      S_AIM: begin
        if (at_target)            state_d = S_DONE;
        else if (delta_c == 3'd0) state_d = S_STEP;
        else                      state_d = S_TURN;
      end
      S_TURN: if (dir_turn == desired_q) state_d = S_STEP;
      S_STEP: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_AIM, S_TURN, S_STEP: busy = 1'b1;
      S_DONE:                done = 1'b1;
      default: ;
    endcase
    arrived = arrived_q;
    X_out   = x_q;
    Y_out   = y_q;
    dir_out = dir_q;
    turns   = turns_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q       <= '0;
      y_q       <= '0;
      dir_q     <= '0;
      turns_q   <= '0;
      tgt_x_q   <= '0;
      tgt_y_q   <= '0;
      desired_q <= '0;
      right_q   <= 1'b0;
      arrived_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          x_q       <= X_in;
          y_q       <= Y_in;
          dir_q     <= dir_in;
          tgt_x_q   <= tgt_X;
          tgt_y_q   <= tgt_Y;
          turns_q   <= '0;
          arrived_q <= 1'b0;
        end
        S_AIM: begin
          desired_q <= desired_c;
          right_q   <= (delta_c <= 3'd4);  // a half-turn tie goes right
          arrived_q <= at_target;
        end
        S_TURN: begin
          dir_q   <= dir_turn;
          turns_q <= turns_q + 3'd1;
        end
        S_STEP: begin
          x_q <= x_step;
          y_q <= y_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ant_steer.md
Name: ant_steer

Overview:
- Sequential inverse of the ant neighbour-location mapping: given an ant's position, heading and a target cell, it derives the octant heading toward the target.
- It rotates the heading one octant per cycle by the shortest path, then steps the ant one cell forward.
- It sits between the ant behaviour controller (which issues targets) and the ant state memory (which stores X/Y/dir).
- Heading encoding, shared codebase-wide: 0=N(Y-1), 1=NE, 2=E(X+1), 3=SE, 4=S(Y+1), 5=SW, 6=W(X-1), 7=NW.
- Right turn is dir+1 mod 8; left turn is dir-1 mod 8.

Parameters:
X_bits, 8, X coordinate width (from params.sv; the grid wraps modulo 2^X_bits)
Y_bits, 7, Y coordinate width (from params.sv; the grid wraps modulo 2^Y_bits)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
X_in  input  X_bits  current ant X
Y_in  input  Y_bits  current ant Y
dir_in  input  3  current ant heading
tgt_X  input  X_bits  target X
tgt_Y  input  Y_bits  target Y
busy  output  1  high in AIM, TURN and STEP
done  output  1  one-cycle completion pulse
arrived  output  1  valid with done; 1 = target equals current position, no move made
X_out  output  X_bits  registered ant X
Y_out  output  Y_bits  registered ant Y
dir_out  output  3  registered ant heading
turns  output  3  number of octant turns taken by the last request

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; busy, done, arrived, X_out, Y_out, dir_out and turns all 0. Any in-flight request is discarded.
- IDLE: outputs hold their last values. If start=1 at an edge:
  - latch X_in/Y_in/dir_in into X_out/Y_out/dir_out;
  - latch tgt_X/tgt_Y internally;
  - clear turns; go to AIM.
- start is ignored in all states other than IDLE, including DONE.
- AIM (one cycle), compute:
  - dx = tgt_X - X_out mod 2^X_bits; dy = tgt_Y - Y_out mod 2^Y_bits; both read as two's complement, so wrap-around takes the shortest toroidal path.
  - The most negative value (e.g. dx=0x80) counts as negative.
  - sx = sign(dx), sy = sign(dy), each in {-1, 0, +1}.
  - desired dir from (sx,sy): (0,-1)→0, (+1,-1)→1, (+1,0)→2, (+1,+1)→3, (0,+1)→4, (-1,+1)→5, (-1,0)→6, (-1,-1)→7.
  - delta = desired - dir_out mod 8.
- AIM transitions:
  - dx=dy=0 → DONE with arrived=1, no turn, no step.
  - delta=0 → STEP.
  - otherwise → TURN. Direction: right when delta is 1..4 (a tie at 4 turns right); left when delta is 5..7.
- TURN: each cycle dir_out ±1 mod 8 and turns+1. Leave for STEP at the edge where the updated dir_out equals desired. At most 4 TURN cycles.
- STEP (one cycle): X_out/Y_out move to the front cell of dir_out. N/S change Y by ±1; E/W change X by ±1; diagonals change both. Arithmetic wraps modulo field width (0-1 → max, max+1 → 0). Then go to DONE.
- DONE (one cycle): done=1, busy=0, arrived valid. Next state IDLE. arrived clears on the next accepted start.
- Latency from the start edge T: no-turn move has done high in cycle T+3; k turns gives done at T+3+k; arrived case gives done at T+2.
- X_in/Y_in/dir_in/tgt changes after the start edge have no effect on the current request.

Test Plan:
1. Assert Reset mid-TURN, release → all outputs 0, state IDLE. A following start is accepted normally.
2. X_in=10, Y_in=10, dir_in=2, tgt=(15,10), start → no turns; done at T+3; X_out=11, Y_out=10, dir_out=2, turns=0, arrived=0.
3. X=10, Y=10, dir=0, tgt=(5,15) (desired 5, delta 5) → left turns 7, 6, 5; done at T+6; X_out=9, Y_out=11, dir_out=5, turns=3.
4. X=10, Y=10, dir=0, tgt=(10,20) (delta 4 tie) → right turns 1, 2, 3, 4; done at T+7; X_out=10, Y_out=11, dir_out=4, turns=4.
5. Wrap: X=255, Y=0, dir=1, tgt=(2,126) → dx=+3, dy=-2, desired 1; no turn; X_out=0, Y_out=127, done at T+3.
6. tgt=(X_in,Y_in)=(40,40), dir=6 → done at T+2, arrived=1, outputs unchanged. A start pulse asserted while busy in a separate request is ignored (no restart, same completion cycle).
